// File: rtl/rv32i_mdu_seq.sv
// rv32i_mdu_seq -- multi-cycle RV32M multiply/divide sequencer beside the execute stage.
//
// A radix-2 shift-add multiplier and a restoring divider share one adder.
// A four-state FSM (IDLE, MUL, DIV, DONE) steps them. Operands are reduced to
// magnitudes on accept, and the sign is fixed on the final step. ISA-defined
// divide special cases finish in one cycle.
//
// Optional feature macro: MDU_EARLY_OUT_EN
//   defined   : MUL* with a zero operand, and DIVU/REMU by one, also finish in one cycle.
//   undefined : every operation except the divide special cases takes NITER+1 cycles.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   start_in     in   ID stage presents a valid instruction this cycle
//   iw_in        in   instruction word (M-type: opcode 0110011, func7 0000001)
//   rs1_data_in  in   operand A
//   rs2_data_in  in   operand B
//   wb_reg_in    in   destination register
//   flush_in     in   aborts any operation in flight
//   stall_out    out  holds the IF/ID/EX stages
//   busy_out     out  FSM is in MUL or DIV
//   done_out     out  result_out/wb_reg_out valid; also the writeback enable
//   result_out   out  rd value, held until the next accept
//   wb_reg_out   out  latched destination register
module rv32i_mdu_seq #(
   parameter int XLEN           = 32,
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_in,
   input  logic [31:0]     iw_in,
   input  logic [XLEN-1:0] rs1_data_in,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [4:0]      wb_reg_in,
   input  logic            flush_in,
   output logic            stall_out,
   output logic            busy_out,
   output logic            done_out,
   output logic [XLEN-1:0] result_out,
   output logic [4:0]      wb_reg_out
);

   localparam int NITER = XLEN / ITER_PER_CYCLE;
   localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t              state_r, state_n;
   logic [CW-1:0]       cnt_r;
   logic [2:0]          f3_r;
   logic                neg_r;
   logic [XLEN-1:0]     hi_r, lo_r, b_r;
   logic                done_r;
   logic [XLEN-1:0]     result_r;
   logic [4:0]          wb_reg_r;

   logic                is_mtype_s, accept_s, busy_s, last_s;
   logic [2:0]          f3_s;
   logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s, res_neg_s;
   logic [XLEN-1:0]     a_mag_s, b_mag_s;
   logic                special_s;
   logic [XLEN-1:0]     special_res_s;
   logic [XLEN+1:0]     add_a_s, add_b_s, sum_s;
   logic                add_c_s;
   logic [XLEN-1:0]     hi_n_s, lo_n_s;
   logic [2*XLEN-1:0]   prod_s, prod_fix_s;
   logic [XLEN-1:0]     quot_fix_s, rem_fix_s, iter_res_s;
   logic                unused_s;

   // Instruction fields other than opcode/func7/func3 are not needed here.
   assign unused_s = ^{iw_in[24:15], iw_in[11:7]};

   assign f3_s       = iw_in[14:12];
   assign is_mtype_s = (iw_in[6:0] == 7'b0110011) && (iw_in[31:25] == 7'b0000001);
   assign accept_s   = start_in && is_mtype_s && !flush_in &&
                       ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign busy_s     = (state_r == ST_MUL) || (state_r == ST_DIV);
   assign last_s     = (cnt_r == CW'(NITER - 1));

   // Operand signedness: MULH/DIV/REM signed on both, MULHSU on rs1 only.
   // MUL is treated as unsigned since its low word does not depend on sign.
   assign a_signed_s = (f3_s == 3'b001) || (f3_s == 3'b010) || (f3_s == 3'b100) || (f3_s == 3'b110);
   assign b_signed_s = (f3_s == 3'b001) || (f3_s == 3'b100) || (f3_s == 3'b110);
   assign a_neg_s    = a_signed_s && rs1_data_in[XLEN-1];
   assign b_neg_s    = b_signed_s && rs2_data_in[XLEN-1];
   assign a_mag_s    = a_neg_s ? (~rs1_data_in + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_data_in;
   assign b_mag_s    = b_neg_s ? (~rs2_data_in + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_data_in;
   // Remainder takes the dividend's sign; everything else is the product of signs.
   assign res_neg_s  = (f3_s[2:1] == 2'b11) ? a_neg_s : (a_neg_s ^ b_neg_s);

   // Detect operations whose result is known at accept time and skip iteration.
   always_comb begin
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
      if (f3_s[2]) begin
         if (rs2_data_in == {XLEN{1'b0}}) begin
            special_s     = 1'b1;
            special_res_s = f3_s[1] ? rs1_data_in : {XLEN{1'b1}};
         end
         else if (!f3_s[0] && (rs1_data_in == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (rs2_data_in == {XLEN{1'b1}})) begin
            special_s     = 1'b1;
            special_res_s = f3_s[1] ? {XLEN{1'b0}} : rs1_data_in;
         end
`ifdef MDU_EARLY_OUT_EN
         else if (f3_s[0] && (rs2_data_in == {{(XLEN-1){1'b0}}, 1'b1})) begin
            special_s     = 1'b1;
            special_res_s = f3_s[1] ? {XLEN{1'b0}} : rs1_data_in;
         end
`endif
         else begin
            special_s = 1'b0;
         end
      end else begin
`ifdef MDU_EARLY_OUT_EN
         if ((rs1_data_in == {XLEN{1'b0}}) || (rs2_data_in == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_res_s = {XLEN{1'b0}};
         end else begin
            special_s = 1'b0;
         end
`else
         special_s = 1'b0;
`endif
      end
   end

   assign stall_out = (accept_s && !special_s) || busy_s;
   assign busy_out  = busy_s;

   // Iteration steps through the shared adder. MUL: hi += b when lo[0], then
   // shift {carry,hi,lo} right. DIV: shift {hi,lo} left, then trial-subtract b
   // from the partial remainder and shift the quotient bit into lo.
   always_comb begin
      hi_n_s  = hi_r;
      lo_n_s  = lo_r;
      add_a_s = {(XLEN+2){1'b0}};
      add_b_s = {(XLEN+2){1'b0}};
      add_c_s = 1'b0;
      sum_s   = {(XLEN+2){1'b0}};
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         if (state_r == ST_MUL) begin
            add_a_s = {2'b00, hi_n_s};
            add_b_s = lo_n_s[0] ? {2'b00, b_r} : {(XLEN+2){1'b0}};
            add_c_s = 1'b0;
         end else begin
            add_a_s = {1'b0, hi_n_s, lo_n_s[XLEN-1]};
            add_b_s = ~{2'b00, b_r};
            add_c_s = 1'b1;
         end
         sum_s = add_a_s + add_b_s + {{(XLEN+1){1'b0}}, add_c_s};
         if (state_r == ST_MUL) begin
            hi_n_s = sum_s[XLEN:1];
            lo_n_s = {sum_s[0], lo_n_s[XLEN-1:1]};
         end else if (!sum_s[XLEN+1]) begin
            hi_n_s = sum_s[XLEN-1:0];
            lo_n_s = {lo_n_s[XLEN-2:0], 1'b1};
         end else begin
            hi_n_s = add_a_s[XLEN-1:0];
            lo_n_s = {lo_n_s[XLEN-2:0], 1'b0};
         end
      end
   end

   assign prod_s     = {hi_n_s, lo_n_s};
   assign prod_fix_s = neg_r ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
   assign quot_fix_s = neg_r ? (~lo_n_s + {{(XLEN-1){1'b0}}, 1'b1}) : lo_n_s;
   assign rem_fix_s  = neg_r ? (~hi_n_s + {{(XLEN-1){1'b0}}, 1'b1}) : hi_n_s;

   // Select the sign-fixed final result from the state after the last step.
   always_comb begin
      iter_res_s = {XLEN{1'b0}};
      case (f3_r)
         3'b000:                 iter_res_s = prod_fix_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: iter_res_s = prod_fix_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         iter_res_s = quot_fix_s;
         3'b110, 3'b111:         iter_res_s = rem_fix_s;
         default:                iter_res_s = {XLEN{1'b0}};
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // FSM next state; flush wins over everything, accept is legal only in IDLE/DONE.
   always_comb begin
      state_n = state_r;
      if (flush_in) begin
         state_n = ST_IDLE;
      end else if (accept_s) begin
         if (special_s) begin
            state_n = ST_DONE;
         end else if (f3_s[2]) begin
            state_n = ST_DIV;
         end else begin
            state_n = ST_MUL;
         end
      end else begin
         case (state_r)
            ST_MUL, ST_DIV: state_n = last_s ? ST_DONE : state_r;
            ST_DONE:        state_n = ST_IDLE;
            ST_IDLE:        state_n = ST_IDLE;
            default:        state_n = ST_IDLE;
         endcase
      end
   end

   // Datapath, iteration counter and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r    <= {CW{1'b0}};
         f3_r     <= 3'b000;
         neg_r    <= 1'b0;
         hi_r     <= {XLEN{1'b0}};
         lo_r     <= {XLEN{1'b0}};
         b_r      <= {XLEN{1'b0}};
         done_r   <= 1'b0;
         result_r <= {XLEN{1'b0}};
         wb_reg_r <= 5'd0;
      end else if (flush_in) begin
         // Abort: result_out keeps the last completed value.
         cnt_r  <= {CW{1'b0}};
         done_r <= 1'b0;
      end else if (accept_s) begin
         f3_r     <= f3_s;
         neg_r    <= res_neg_s;
         wb_reg_r <= wb_reg_in;
         cnt_r    <= {CW{1'b0}};
         hi_r     <= {XLEN{1'b0}};
         lo_r     <= a_mag_s;
         b_r      <= b_mag_s;
         done_r   <= special_s;
         if (special_s) begin
            result_r <= special_res_s;
         end else begin
            result_r <= result_r;
         end
      end else if (busy_s) begin
         hi_r <= hi_n_s;
         lo_r <= lo_n_s;
         if (last_s) begin
            cnt_r    <= {CW{1'b0}};
            done_r   <= 1'b1;
            result_r <= iter_res_s;
         end else begin
            cnt_r  <= cnt_r + CW'(1);
            done_r <= 1'b0;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign done_out   = done_r;
   assign result_out = result_r;
   assign wb_reg_out = wb_reg_r;

endmodule

// File: tb/tb_rv32i_mdu_seq.sv
// tb_rv32i_mdu_seq -- self-checking bench for rv32i_mdu_seq.
// Directed ISA cases plus $urandom operands, checked against a plain-arithmetic
// model of the RV32M rules and the expected accept-to-done latency.
module tb_rv32i_mdu_seq;

   localparam int NITER = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_in;
   logic [31:0] iw_in;
   logic [31:0] rs1_data_in;
   logic [31:0] rs2_data_in;
   logic [4:0]  wb_reg_in;
   logic        flush_in;
   logic        stall_out;
   logic        busy_out;
   logic        done_out;
   logic [31:0] result_out;
   logic [4:0]  wb_reg_out;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_exp = 32'h0;

   always #5 clk = ~clk;

   rv32i_mdu_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start_in    (start_in),
      .iw_in       (iw_in),
      .rs1_data_in (rs1_data_in),
      .rs2_data_in (rs2_data_in),
      .wb_reg_in   (wb_reg_in),
      .flush_in    (flush_in),
      .stall_out   (stall_out),
      .busy_out    (busy_out),
      .done_out    (done_out),
      .result_out  (result_out),
      .wb_reg_out  (wb_reg_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_iw(input logic [2:0] f3, input logic [4:0] rd);
      return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   // RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub, p;
      logic [63:0] pu;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'h0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   // One-cycle operations: divide by zero and signed overflow, plus early-outs when enabled.
   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bit s;
      s = f3[2] && ((b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MDU_EARLY_OUT_EN
      s = s || (!f3[2] && (a == 32'h0 || b == 32'h0)) || (f3[2] && f3[0] && b == 32'h1);
`endif
      return s;
   endfunction

   // Issue one M op. chain=1 leaves the DUT in DONE so the next call issues back-to-back.
   // poke=1 raises start_in with a DIV for one cycle mid-iteration; it must be ignored.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit chain, input bit poke);
      logic [31:0] exp_res;
      bit          sp;
      int          k;
      exp_res = ref_mdu(f3, a, b);
      sp      = is_special(f3, a, b);
      @(negedge clk);
      start_in    = 1'b1;
      iw_in       = mk_iw(f3, rd);
      rs1_data_in = a;
      rs2_data_in = b;
      wb_reg_in   = rd;
      #1 check("stall_accept", {31'h0, stall_out}, sp ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      start_in    = 1'b0;
      rs1_data_in = $urandom;
      rs2_data_in = $urandom;
      wb_reg_in   = 5'($urandom);
      if (sp) check("stall_special", {31'h0, stall_out}, 32'd0);
      else    check("busy_iter", {31'h0, busy_out}, 32'd1);
      k = 0;
      while (!done_out && k < NITER + 8) begin
         if (poke && k == 5) begin
            start_in = 1'b1;
            iw_in    = mk_iw(3'b101, 5'd31);
         end else begin
            start_in = 1'b0;
         end
         @(posedge clk);
         #1;
         k++;
      end
      start_in = 1'b0;
      check("latency", 32'(k), sp ? 32'd0 : 32'(NITER));
      check("result", result_out, exp_res);
      check("wb_reg", {27'h0, wb_reg_out}, {27'h0, rd});
      last_exp = exp_res;
      if (!chain) begin
         @(posedge clk);
         #1;
         check("done_pulse", {31'h0, done_out}, 32'd0);
         check("result_hold", result_out, exp_res);
      end
   endtask

   initial begin
      int seen;
      logic [31:0] ra, rb;
      reset       = 1'b0;
      start_in    = 1'b0;
      flush_in    = 1'b0;
      iw_in       = 32'h0;
      rs1_data_in = 32'h0;
      rs2_data_in = 32'h0;
      wb_reg_in   = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_done",   {31'h0, done_out},  32'd0);
      check("rst_busy",   {31'h0, busy_out},  32'd0);
      check("rst_stall",  {31'h0, stall_out}, 32'd0);
      check("rst_result", result_out,         32'd0);
      check("rst_wb",     {27'h0, wb_reg_out}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed ISA cases.
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, 1'b0, 1'b1);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0, 1'b0);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b0, 1'b0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd14, 1'b0, 1'b0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd15, 1'b0, 1'b0);
      do_op(3'd5, 32'd100, 32'd7, 5'd16, 1'b0, 1'b0);
      do_op(3'd7, 32'd100, 32'd7, 5'd17, 1'b0, 1'b0);
      do_op(3'd5, 32'd5, 32'd0, 5'd18, 1'b0, 1'b0);
      do_op(3'd6, 32'd5, 32'd0, 5'd19, 1'b0, 1'b0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b0, 1'b0);
      do_op(3'd0, 32'h1234_5678, 32'd0, 5'd21, 1'b0, 1'b0);
      do_op(3'd7, 32'hDEAD_BEEF, 32'd1, 5'd22, 1'b0, 1'b0);

      // Back-to-back: second MUL issued in the DONE cycle of the first.
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 1'b0);
      do_op(3'd0, 32'h0001_2345, 32'h0000_0055, 5'd4, 1'b1, 1'b0);
      do_op(3'd4, 32'd5, 32'd0, 5'd6, 1'b0, 1'b0);

      // Randomized operands over every func3, with biased divisor/overflow rounds.
      for (int r = 0; r < 6; r++) begin
         for (int f = 0; f < 8; f++) begin
            ra = $urandom;
            rb = $urandom;
            if (r == 1) rb = 32'h0;
            if (r == 2) rb = 32'($urandom_range(1, 15));
            if (r == 3) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (r == 4) ra = 32'($urandom_range(0, 3));
            do_op(3'(f), ra, rb, 5'($urandom), 1'b0, (r == 0));
         end
      end

      // Non-M instruction (ADD) must be ignored.
      @(negedge clk);
      start_in = 1'b1;
      iw_in    = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011};
      #1 check("nonm_stall", {31'h0, stall_out}, 32'd0);
      @(posedge clk);
      #1;
      start_in = 1'b0;
      check("nonm_busy", {31'h0, busy_out}, 32'd0);
      check("nonm_done", {31'h0, done_out}, 32'd0);

      // Flush together with start_in: flush wins.
      @(negedge clk);
      start_in    = 1'b1;
      flush_in    = 1'b1;
      iw_in       = mk_iw(3'd0, 5'd8);
      rs1_data_in = 32'd3;
      rs2_data_in = 32'd4;
      #1 check("flushstart_stall", {31'h0, stall_out}, 32'd0);
      @(posedge clk);
      #1;
      start_in = 1'b0;
      flush_in = 1'b0;
      check("flushstart_busy", {31'h0, busy_out}, 32'd0);

      // MUL aborted by flush at cycle 10: no done_out, result unchanged.
      @(negedge clk);
      start_in    = 1'b1;
      iw_in       = mk_iw(3'd0, 5'd9);
      rs1_data_in = 32'd5;
      rs2_data_in = 32'd6;
      wb_reg_in   = 5'd9;
      @(posedge clk);
      #1;
      start_in = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush_in = 1'b1;
      @(posedge clk);
      #1;
      flush_in = 1'b0;
      check("flush_busy",  {31'h0, busy_out},  32'd0);
      check("flush_stall", {31'h0, stall_out}, 32'd0);
      seen = 0;
      for (int c = 0; c < NITER + 4; c++) begin
         if (done_out) seen++;
         @(posedge clk);
         #1;
      end
      check("flush_no_done", 32'(seen), 32'd0);
      check("flush_result_hold", result_out, last_exp);

      // Reset asserted mid-DIV clears all outputs at once.
      do_op(3'd7, 32'd1000, 32'd7, 5'd23, 1'b0, 1'b0);
      @(negedge clk);
      start_in    = 1'b1;
      iw_in       = mk_iw(3'd4, 5'd17);
      rs1_data_in = 32'd1000;
      rs2_data_in = 32'd3;
      wb_reg_in   = 5'd17;
      @(posedge clk);
      #1;
      start_in = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_done",   {31'h0, done_out},   32'd0);
      check("arst_busy",   {31'h0, busy_out},   32'd0);
      check("arst_stall",  {31'h0, stall_out},  32'd0);
      check("arst_result", result_out,          32'd0);
      check("arst_wb",     {27'h0, wb_reg_out}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      do_op(3'd2, 32'hFFFF_FF00, 32'hFFFF_FFFF, 5'd25, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
